byte_burst_serializer: RTL and testbench
========================================

// Module: byte_burst_serializer
// PURPOSE
//   Producer-side counterpart of the 4-byte stream accumulator. Accepts one packed
//   word of NUM bytes over a valid/ready handshake and emits it as NUM sequential
//   bytes on a valid/ready byte stream, LSB byte first, flagging the final byte.
//   Also produces the SUM_W-bit sum of the bytes it sent, as a reference for checking
//   the downstream accumulator result.
// PARAMETERS
//   DATA_W  8   width of one byte-stream beat
//   NUM     4   beats per word (>=2)
//   SUM_W   10  sum width = DATA_W + clog2(NUM)
// PORTS
//   clk        in   1             clock; all state updates on posedge
//   rst_n      in   1             asynchronous, active-low reset
//   in_valid   in   1             packed word available
//   in_ready   out  1             block can take a word this cycle
//   in_data    in   NUM*DATA_W    packed word; beat k = in_data[k*DATA_W +: DATA_W]
//   out_valid  out  1             out_data holds a valid beat
//   out_ready  in   1             downstream accepts the beat
//   out_data   out  DATA_W        current beat
//   out_last   out  1             current beat is beat NUM-1 of the word
//   sum_valid  out  1             one-cycle pulse: sum_out is valid
//   sum_out    out  SUM_W         sum of the NUM beats of the word just completed
// BEHAVIOUR
//   - Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, sum_valid=0,
//     sum_out=0. Internal word register, beat counter and sum register clear to 0.
//   - Word transfer: in_valid&&in_ready. Beat transfer: out_valid&&out_ready.
//   - FSM IDLE: out_valid=0, in_ready=1. A word transfer stores the word, sets cnt=0,
//     loads out_data=beat0, sets out_valid=1 and goes to SEND.
//     The first beat is visible the cycle after acceptance.
//   - FSM SEND: out_valid=1. out_data and out_last hold stable while !out_ready.
//     On a beat transfer with cnt<NUM-1: cnt++, out_data=next beat.
//     out_last=1 exactly when cnt==NUM-1.
//   - Last-beat transfer (cnt==NUM-1): sum_out=acc+out_data, sum_valid=1 for one
//     cycle, acc clears.
//     If a word transfer happens in the same cycle, reload and stay in SEND with no
//     bubble. Otherwise go to IDLE.
//   - in_ready = IDLE || (SEND && cnt==NUM-1 && out_ready). This is combinational from
//     out_ready and gives back-to-back words with zero idle cycles.
//   - acc adds each transferred beat, zero-extended to SUM_W. No overflow is possible
//     with SUM_W=DATA_W+clog2(NUM).
//   - in_valid while !in_ready is ignored; the upstream side holds in_valid and
//     in_data.
//   - sum_out keeps its last value between sum_valid pulses.
//   - Reset mid-burst aborts the word immediately. No sum_valid is produced for it,
//     and all outputs return to reset values.
// TESTING
//   1 in_data=32'h04030201, out_ready=1 -> out_data 01,02,03,04 on 4 consecutive
//     cycles starting 1 cycle after accept; out_last only on 04; sum_valid with
//     sum_out=10'h00A in the same cycle as the beat-04 transfer.
//   2 in_data=32'hFFFFFFFF -> four beats of FF; sum_out=10'h3FC (no overflow).
//   3 Backpressure: out_ready low 3 cycles during beat 02 -> out_data=02 held stable,
//     out_valid held 1, in_ready=0; resumes 03,04 with the sum unchanged
//     (10'h00A).
//   4 Back-to-back: in_valid held high with words 32'h04030201 then 32'h80808080 ->
//     8 consecutive beats with no bubble; sum pulses 10'h00A then 10'h200.
//   5 rst_n asserted after beat 01 of 32'h04030201 -> outputs at reset values, no
//     sum_valid. After release, the next word 32'h01010101 gives sum_out=10'h004.
//   6 in_valid while busy and out_ready=0 -> word not taken (in_ready=0); taken in the
//     cycle the last beat is transferred.

Source files
------------

// File: rtl/byte_burst_serializer.sv
// Splits one packed NUM-byte word into NUM byte beats (LSB first) and reports the sum of the beats sent.
// First beat 1 cycle after accept; in_ready is combinational from out_ready so words follow each other with no bubble.
module byte_burst_serializer #(
  parameter int DATA_W = 8,
  parameter int NUM    = 4,
  parameter int SUM_W  = DATA_W + $clog2(NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [NUM*DATA_W-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_W-1:0]     out_data_o,
  output logic                  out_last_o,
  output logic                  sum_valid_o,
  output logic [SUM_W-1:0]      sum_out_o
);

  localparam int WORD_W = NUM * DATA_W;
  localparam int CNT_W  = $clog2(NUM);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [SUM_W-1:0]    sum_q, sum_d;

  logic                beat_xfer;
  logic                last_xfer;
  logic                in_ready;
  logic                word_xfer;
  logic [SUM_W-1:0]    beat_ext;
  logic [SUM_W-1:0]    sum_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    beat_xfer = (state_q == SEND) && out_ready_i;
    last_xfer = beat_xfer && (cnt_q == LAST_CNT);
    in_ready  = (state_q == IDLE) || last_xfer;
    word_xfer = in_valid_i && in_ready;
    beat_ext  = {{(SUM_W - DATA_W){1'b0}}, word_q[DATA_W-1:0]};
    sum_now   = acc_q + beat_ext;

    if (last_xfer) begin
      sum_d   = sum_now;
      acc_d   = '0;
      state_d = IDLE;
    end else if (beat_xfer) begin
      // The word register shifts right so the current beat always sits in the low byte.
      acc_d  = sum_now;
      cnt_d  = cnt_q + 1'b1;
      word_d = {{DATA_W{1'b0}}, word_q[WORD_W-1:DATA_W]};
    end

    if (word_xfer) begin
      word_d  = in_data_i;
      cnt_d   = '0;
      state_d = SEND;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = (state_q == SEND);
  assign out_data_o  = word_q[DATA_W-1:0];
  assign out_last_o  = (state_q == SEND) && (cnt_q == LAST_CNT);
  // The sum pulse coincides with the last-beat transfer; between pulses the registered copy holds.
  assign sum_valid_o = last_xfer;
  assign sum_out_o   = last_xfer ? sum_now : sum_q;

endmodule

// File: tb/tb_byte_burst_serializer.sv
// Directed bench for byte_burst_serializer: a queue model of pending beats and sums checks every cycle,
// and per-test literal expectations pin beat order, timing and sums.
module tb_byte_burst_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        sum_valid;
  logic [9:0]  sum_out;

  byte_burst_serializer #(.DATA_W(8), .NUM(4), .SUM_W(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .sum_valid_o (sum_valid),
    .sum_out_o   (sum_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: pending beats {last, data} and expected sums per accepted word.
  logic [8:0] exp_q[$];
  logic [9:0] exp_sum_q[$];
  logic [9:0] last_sum;
  logic [8:0] b;
  logic [9:0] s;

  // Logs for the literal per-test expectations.
  logic [7:0] beat_dat[$];
  logic       beat_last[$];
  int         beat_cyc[$];
  logic [9:0] sum_log[$];
  int         sum_cyc[$];
  int         acc_cyc[$];

  task automatic clear_logs();
    beat_dat.delete(); beat_last.delete(); beat_cyc.delete();
    sum_log.delete(); sum_cyc.delete(); acc_cyc.delete();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_sum_q.delete();
      last_sum = '0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_sum_valid", sum_valid, 0);
      chk("rst_sum_out", sum_out, 0);
    end else begin
      chk("model_out_valid", out_valid, exp_q.size() != 0);
      chk("model_in_ready", in_ready,
          (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready));
      if (out_valid && out_ready && exp_q.size() != 0) begin
        b = exp_q.pop_front();
        chk("model_out_data", out_data, b[7:0]);
        chk("model_out_last", out_last, b[8]);
        chk("model_sum_valid", sum_valid, b[8]);
        beat_dat.push_back(out_data);
        beat_last.push_back(out_last);
        beat_cyc.push_back(cyc);
        if (b[8]) begin
          s = exp_sum_q.pop_front();
          chk("model_sum_out", sum_out, s);
          last_sum = s;
        end else begin
          chk("model_sum_hold", sum_out, last_sum);
        end
      end else begin
        chk("model_no_sum", sum_valid, 0);
        chk("model_sum_hold", sum_out, last_sum);
      end
      if (sum_valid) begin
        sum_log.push_back(sum_out);
        sum_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        s = '0;
        for (int k = 0; k < 4; k++) begin
          exp_q.push_back({k == 3, in_data[k*8 +: 8]});
          s = s + {2'b00, in_data[k*8 +: 8]};
        end
        exp_sum_q.push_back(s);
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] t1 [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0] t4 [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h80, 8'h80, 8'h80, 8'h80};
  logic [7:0] t6 [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0D, 8'h0C, 8'h0B, 8'h0A};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: single word, no backpressure
    clear_logs();
    send_word(32'h04030201);
    idle_in();
    wait_cycles(6);
    chk("t1_beats", beat_dat.size(), 4);
    chk("t1_sums", sum_log.size(), 1);
    if (beat_dat.size() == 4 && acc_cyc.size() == 1) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_data", beat_dat[i], t1[i]);
        chk("t1_last", beat_last[i], i == 3);
        chk("t1_cycle", beat_cyc[i], acc_cyc[0] + 1 + i);
      end
    end
    if (sum_log.size() == 1 && beat_cyc.size() == 4) begin
      chk("t1_sum", sum_log[0], 10'h00A);
      chk("t1_sum_cycle", sum_cyc[0], beat_cyc[3]);
    end

    // 2: all ones, maximum sum
    clear_logs();
    send_word(32'hFFFFFFFF);
    idle_in();
    wait_cycles(6);
    chk("t2_beats", beat_dat.size(), 4);
    chk("t2_sums", sum_log.size(), 1);
    if (sum_log.size() == 1) chk("t2_sum", sum_log[0], 10'h3FC);

    // 3: backpressure on beat 02
    clear_logs();
    send_word(32'h04030201);
    idle_in();
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_hold_data", out_data, 8'h02);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_last", out_last, 0);
      chk("t3_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_cycles(5);
    chk("t3_beats", beat_dat.size(), 4);
    if (beat_dat.size() == 4)
      for (int i = 0; i < 4; i++) chk("t3_data", beat_dat[i], t1[i]);
    chk("t3_sums", sum_log.size(), 1);
    if (sum_log.size() == 1) chk("t3_sum", sum_log[0], 10'h00A);

    // 4: back-to-back words, no bubble
    clear_logs();
    send_word(32'h04030201);
    send_word(32'h80808080);
    idle_in();
    wait_cycles(10);
    chk("t4_beats", beat_dat.size(), 8);
    if (beat_dat.size() == 8)
      for (int i = 0; i < 8; i++) begin
        chk("t4_data", beat_dat[i], t4[i]);
        chk("t4_cycle", beat_cyc[i], beat_cyc[0] + i);
      end
    chk("t4_sums", sum_log.size(), 2);
    if (sum_log.size() == 2) begin
      chk("t4_sum0", sum_log[0], 10'h00A);
      chk("t4_sum1", sum_log[1], 10'h200);
    end

    // 5: reset after beat 01
    clear_logs();
    send_word(32'h04030201);
    idle_in();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_beats_before_reset", beat_dat.size(), 1);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_sum_valid", sum_valid, 0);
    chk("t5_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_word(32'h01010101);
    idle_in();
    wait_cycles(6);
    chk("t5_sums", sum_log.size(), 1);
    if (sum_log.size() == 1) chk("t5_sum", sum_log[0], 10'h004);

    // 6: word offered while busy is only taken on the last-beat transfer
    clear_logs();
    out_ready = 1'b0;
    send_word(32'h04030201);
    fork
      send_word(32'h0A0B0C0D);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("t6_busy_in_ready", in_ready, 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle_in();
    wait_cycles(8);
    chk("t6_accepts", acc_cyc.size(), 2);
    chk("t6_beats", beat_dat.size(), 8);
    if (acc_cyc.size() == 2 && beat_dat.size() == 8) begin
      chk("t6_accept_cycle", acc_cyc[1], beat_cyc[3]);
      for (int i = 0; i < 8; i++) chk("t6_data", beat_dat[i], t6[i]);
    end
    chk("t6_sums", sum_log.size(), 2);
    if (sum_log.size() == 2) begin
      chk("t6_sum0", sum_log[0], 10'h00A);
      chk("t6_sum1", sum_log[1], 10'h02E);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
